// File: rtl/fifo_byte_serializer.sv
// ---------------------------------------------------------------------------
// fifo_byte_serializer
//
// Pops words from a synchronous move FIFO and emits each one as a framed byte
// stream on a valid/ready link. Each word is zero-extended to 32 bits and sent
// MSB first:
//   byte0 = {1'b1, w[30:24]}   (bit 7 marks start of frame)
//   byte1 = w[23:16], byte2 = w[15:8], byte3 = w[7:0]
// Frames run back to back: the next word is popped in the same cycle the last
// byte of the current frame is accepted, so no idle cycle separates frames.
//
// Optional build macro: FIFO_BYTE_SERIALIZER_CHECKSUM_EN
//   defined   : a 5th byte, the XOR of bytes 0..3, follows byte3.
//   undefined : 4-byte frames, no checksum logic.
//
// Ports:
//   clk          in   system clock, rising edge
//   rstp         in   asynchronous active-high reset
//   fifo_dout    in   FIFO head word, valid while fifo_emptyp=0
//   fifo_emptyp  in   FIFO empty flag
//   fifo_readp   out  combinational pop strobe, one cycle per word
//   byte_data    out  current output byte (registered)
//   byte_valid   out  byte_data valid (registered)
//   byte_ready   in   sink accepts the byte on an edge with valid && ready
//   busy         out  high while a frame is in flight
//   words_sent   out  count of completed frames, wraps silently
// ---------------------------------------------------------------------------
module fifo_byte_serializer #(
    parameter int WORD_W = 27,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_emptyp,
    output logic              fifo_readp,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);

`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    // Bit 31 of the zero-extended word never appears on the link, so only
    // 31 bits are held.
    logic [30:0]      r_word;
    logic [30:0]      w_word_next;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_next;
    logic [7:0]       r_byte;
    logic [7:0]       w_byte_next;
    logic             r_valid;
    logic             w_valid_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_pop;

    logic [30:0]      w_head;
    logic [7:0]       w_head_b0;
    logic [7:0]       w_lane [4];
    logic [7:0]       w_following;

    assign w_head    = 31'(fifo_dout);
    assign w_head_b0 = {1'b1, w_head[30:24]};

    // Byte lanes of the word currently being sent, in transmit order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            if (gi == 0) begin : g_marker
                assign w_lane[gi] = {1'b1, r_word[30:24]};
            end else begin : g_data
                assign w_lane[gi] = r_word[31-8*gi -: 8];
            end
        end
    endgenerate

`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
    logic [7:0] w_csum;
    assign w_csum = w_lane[0] ^ w_lane[1] ^ w_lane[2] ^ w_lane[3];
`endif

    // Byte that follows the one at r_idx within the current frame.
    always_comb begin
        w_following = w_lane[0];
        case (r_idx)
            3'd0:    w_following = w_lane[1];
            3'd1:    w_following = w_lane[2];
            3'd2:    w_following = w_lane[3];
`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
            3'd3:    w_following = w_csum;
`endif
            default: w_following = w_lane[0];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        w_idx_next   = r_idx;
        w_byte_next  = r_byte;
        w_valid_next = r_valid;
        w_count_next = r_count;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!fifo_emptyp) begin
                    w_pop        = 1'b1;
                    w_word_next  = w_head;
                    w_idx_next   = 3'd0;
                    w_byte_next  = w_head_b0;
                    w_valid_next = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // byte_valid is always high in this state.
                if (byte_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_count_next = r_count + 1'b1;
                        if (!fifo_emptyp) begin
                            // Chain straight into the next frame.
                            w_pop       = 1'b1;
                            w_word_next = w_head;
                            w_idx_next  = 3'd0;
                            w_byte_next = w_head_b0;
                        end else begin
                            w_idx_next   = 3'd0;
                            w_valid_next = 1'b0;
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_idx_next  = r_idx + 3'd1;
                        w_byte_next = w_following;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
                w_idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_idx   <= 3'd0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_word  <= w_word_next;
            r_idx   <= w_idx_next;
            r_byte  <= w_byte_next;
            r_valid <= w_valid_next;
            r_count <= w_count_next;
        end
    end

    // Gate the pop with reset so a word is never lost while held in reset.
    assign fifo_readp = w_pop && !rstp;
    assign byte_data  = r_byte;
    assign byte_valid = r_valid;
    assign busy       = (r_state == ST_SEND);
    assign words_sent = r_count;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_byte_serializer
//
// Scoreboard bench: a queue models the FIFO; every pop pushes the expected
// frame bytes, and every accepted byte is compared against the queue head.
// The counter is built 2 bits wide so wrap-around is exercised.
// ---------------------------------------------------------------------------
module tb_fifo_byte_serializer;

    localparam int WORD_W = 27;
    localparam int CNT_W  = 2;
`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic              clk = 1'b0;
    logic              rstp;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_emptyp;
    logic              fifo_readp;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              busy;
    logic [CNT_W-1:0]  words_sent;

    fifo_byte_serializer #(
        .WORD_W(WORD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rstp       (rstp),
        .fifo_dout  (fifo_dout),
        .fifo_emptyp(fifo_emptyp),
        .fifo_readp (fifo_readp),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] fq[$];
    logic [7:0]        exp_q[$];
    logic [CNT_W-1:0]  exp_cnt;
    int                pos;
    int                n_pops;
    int                n_valid;
    int                n_bubbles;
    logic              prev_valid;
    int                checks;
    int                errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [WORD_W-1:0] w);
        logic [31:0] x;
        logic [7:0]  b0, b1, b2, b3;
        x  = 32'(w);
        b0 = 8'h80 | {1'b0, x[30:24]};
        b1 = x[23:16];
        b2 = x[15:8];
        b3 = x[7:0];
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
        exp_q.push_back(b0 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    // One clock cycle: drive the FIFO model, sample after settling, then
    // advance to the next falling edge.
    task automatic tick();
        logic [7:0] e;
        fifo_emptyp = (fq.size() == 0);
        fifo_dout   = (fq.size() != 0) ? fq[0] : '0;
        #1;
        check("words_sent", 32'(words_sent), 32'(exp_cnt));
        if (rstp) check("readp_in_reset", 32'(fifo_readp), 32'd0);
        if (!byte_valid && prev_valid && exp_q.size() != 0 && !rstp) n_bubbles++;
        prev_valid = byte_valid;
        if (byte_valid) n_valid++;
        if (fifo_readp) begin
            n_pops++;
            check("readp_when_empty", 32'(fifo_emptyp), 32'd0);
            if (fq.size() != 0) push_frame(fq.pop_front());
        end
        if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(byte_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("byte", 32'(byte_data), 32'(e));
                $display("byte pos=%0d data=%02h exp=%02h cnt=%0d", pos, byte_data, e, words_sent);
            end
            pos++;
            if (pos == NB) begin
                pos = 0;
                exp_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || byte_valid) && n < budget) begin
            tick();
            n++;
        end
        check("done_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        rstp = 1'b1;
        exp_q.delete();
        pos     = 0;
        exp_cnt = '0;
        tick();
        tick();
        rstp = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        pos        = 0;
        n_pops     = 0;
        n_valid    = 0;
        n_bubbles  = 0;
        prev_valid = 1'b0;
        exp_cnt    = '0;
        rstp        = 1'b1;
        byte_ready  = 1'b0;
        fifo_emptyp = 1'b1;
        fifo_dout   = '0;
        @(negedge clk);
        #1;
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_data", 32'(byte_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(words_sent), 32'd0);
        check("rst_readp", 32'(fifo_readp), 32'd0);
        @(negedge clk);
        rstp = 1'b0;

        // Empty FIFO: nothing happens.
        byte_ready = 1'b1;
        repeat (20) begin
            tick();
            check("empty_readp", 32'(fifo_readp), 32'd0);
            check("empty_valid", 32'(byte_valid), 32'd0);
            check("empty_busy", 32'(busy), 32'd0);
        end

        // Single word with sink always ready.
        n_pops = 0;
        fq.push_back(27'h5A5A5A5);
        run_until_done(50);
        check("single_pops", 32'(n_pops), 32'd1);
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_cnt", 32'(words_sent), 32'd1);

        // Backpressure while byte2 is presented.
        fq.push_back(27'h1234567);
        n = 0;
        while (!(pos == 2 && byte_valid) && n < 50) begin
            tick();
            n++;
        end
        check("bp_reach_byte2", 32'(n < 50), 32'd1);
        byte_ready = 1'b0;
        repeat (5) begin
            tick();
            check("bp_hold_valid", 32'(byte_valid), 32'd1);
            check("bp_hold_data", 32'(byte_data), 32'h45);
        end
        byte_ready = 1'b1;
        run_until_done(50);

        // Back-to-back frames, no bubble allowed.
        n_pops     = 0;
        n_valid    = 0;
        n_bubbles  = 0;
        fq.push_back(27'h0000000);
        fq.push_back(27'h7FFFFFF);
        run_until_done(60);
        check("b2b_pops", 32'(n_pops), 32'd2);
        check("b2b_valid_cycles", 32'(n_valid), 32'(2 * NB));
        check("b2b_bubbles", 32'(n_bubbles), 32'd0);

        // Reset after byte1 accepted: frame dropped, next word starts clean.
        fq.push_back(27'h1234567);
        fq.push_back(27'h0ABCDEF);
        n = 0;
        while (pos != 2 && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_reach", 32'(n < 50), 32'd1);
        rstp = 1'b1;
        #1;
        check("rst_mid_valid", 32'(byte_valid), 32'd0);
        check("rst_mid_cnt", 32'(words_sent), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_readp", 32'(fifo_readp), 32'd0);
        exp_q.delete();
        pos     = 0;
        exp_cnt = '0;
        @(negedge clk);
        tick();
        tick();
        rstp = 1'b0;
        check("rst_mid_fifo_left", 32'(fq.size()), 32'd1);
        run_until_done(50);
        check("rst_mid_cnt_after", 32'(words_sent), 32'd1);

        // Counter wrap with a 2-bit counter: 1,2,3,0,1.
        do_reset();
        fq.push_back(27'h0000001);
        fq.push_back(27'h4000000);
        fq.push_back(27'h2AAAAAA);
        fq.push_back(27'h5555555);
        fq.push_back(27'h00FF00F);
        run_until_done(100);
        check("wrap_final_cnt", 32'(words_sent), 32'd1);
        check("wrap_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
